// File: rtl/nrisc_pkg.sv
// Shared nRISC constants: fetch FSM encoding, address width, program defaults.
// No logic; pure declarations.
// Imported by the fetch stage and its counter so every block agrees on widths.
package nrisc_pkg;

  // Address/PC width, matches bancoInstrucoes endereco
  localparam int LARGURA = 8;

  // Defaults shared with bancoInstrucoes: program size and boot address
  localparam int NUM_INSTR_PADRAO = 11;
  localparam int END_RESET_PADRAO = 0;

  // Fetch FSM encoding, kept as plain constants for legacy compatibility
  typedef logic [1:0] estado_t;
  localparam logic [1:0] INICIO = 2'd0;
  localparam logic [1:0] BUSCA  = 2'd1;
  localparam logic [1:0] FIM    = 2'd2;

endpackage

// File: rtl/busca_instrucao_if.sv
// Fetch <-> decoder bundle: stall/redirect in, address and fetch status out.
// Wires only, no latency.
// stall holds the current word; desvio redirects fetch with no bubble.
interface busca_instrucao_if #(
  parameter int LARGURA = nrisc_pkg::LARGURA
) ();

  logic               stall;
  logic               desvio;
  logic [LARGURA-1:0] desvio_alvo;
  logic [LARGURA-1:0] endereco;
  logic [LARGURA-1:0] pc_inst;
  logic               inst_valida;
  logic               fim;
  logic [LARGURA-1:0] contagem;

  // Fetch stage side
  modport master (
    input  stall, desvio, desvio_alvo,
    output endereco, pc_inst, inst_valida, fim, contagem
  );

  // Decoder side
  modport slave (
    output stall, desvio, desvio_alvo,
    input  endereco, pc_inst, inst_valida, fim, contagem
  );

endinterface

// File: rtl/bancoInstrucoes.sv
// Instruction ROM holding the 11-word nRISC program.
// One-cycle registered read: out reflects endereco sampled at the previous edge.
// No backpressure; the fetch stage re-presents an address to hold the output.
module bancoInstrucoes (
  input  logic       clock,
  input  logic [7:0] endereco,
  output logic [7:0] out
);

  // Registered read of the program word at endereco
  always_ff @(posedge clock) begin
    case (endereco)
      8'd0:    out <= 8'b00010001;
      8'd1:    out <= 8'b00100010;
      8'd2:    out <= 8'b01110010;
      8'd3:    out <= 8'b01000011;
      8'd4:    out <= 8'b00101101;
      8'd5:    out <= 8'b01010100;
      8'd6:    out <= 8'b10000101;
      8'd7:    out <= 8'b01100110;
      8'd8:    out <= 8'b10010111;
      8'd9:    out <= 8'b10101000;
      8'd10:   out <= 8'b11110000;
      default: out <= 8'b00000000;
    endcase
  end

endmodule

// File: rtl/busca_instrucao_contador_saturado.sv
// Saturating up-counter with enable and synchronous active-low reset.
// Value updates one edge after habilita is sampled.
// Never wraps: sticks at all-ones once reached.
module contador_saturado #(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               habilita,
  output logic [LARGURA-1:0] valor
);

  localparam logic [LARGURA-1:0] UM = 1;

  // Count enabled edges, holding at the maximum value
  always_ff @(posedge clock) begin
    if (!reset) begin
      valor <= '0;
    end else if (habilita && (valor != '1)) begin
      valor <= valor + UM;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Fetch stage: owns the PC, drives bancoInstrucoes endereco, tracks the word on its output.
// Word at address A appears with pc_inst==A one cycle after endereco==A is sampled.
// stall re-reads pc_inst so the bank output holds; desvio beats stall and costs no bubble.
module busca_instrucao #(
  parameter int LARGURA   = nrisc_pkg::LARGURA,
  parameter int END_RESET = nrisc_pkg::END_RESET_PADRAO,
  parameter int NUM_INSTR = nrisc_pkg::NUM_INSTR_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  busca_instrucao_if.master bus
);

  import nrisc_pkg::*;

  // PC is one bit wider than the address so it can sit at NUM_INSTR without wrapping
  localparam logic [LARGURA:0]   LIMITE     = (LARGURA+1)'(NUM_INSTR);
  localparam logic [LARGURA:0]   PC_INICIAL = (LARGURA+1)'(END_RESET);
  localparam logic [LARGURA:0]   UM         = 1;

  estado_t            estado;
  logic [LARGURA:0]   pc;
  logic [LARGURA-1:0] pc_inst;
  logic               inst_valida;
  logic               fim;
  logic [LARGURA-1:0] prox;
  logic [LARGURA:0]   prox_inc;
  logic               aceita;
  logic [LARGURA-1:0] contagem;

  // Address mux: redirect target, re-read of the held word, or the sequential PC
  always_comb begin
    prox = pc[LARGURA-1:0];
    if ((estado == BUSCA) && bus.desvio) begin
      prox = bus.desvio_alvo;
    end else if (((estado == BUSCA) && bus.stall) || (estado == FIM)) begin
      prox = pc_inst;
    end
    prox_inc = {1'b0, prox} + UM;
  end

  // A valid word leaves on any non-stalled edge, and a taken branch always counts
  assign aceita = inst_valida && (bus.desvio || !bus.stall);

  // PC / fetch-status registers and FSM
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc          <= PC_INICIAL;
      pc_inst     <= PC_INICIAL[LARGURA-1:0];
      inst_valida <= 1'b0;
      fim         <= 1'b0;
      estado      <= INICIO;
    end else begin
      case (estado)
        INICIO: begin
          if (PC_INICIAL >= LIMITE) begin
            inst_valida <= 1'b0;
            fim         <= 1'b1;
            estado      <= FIM;
          end else begin
            pc_inst     <= prox;
            pc          <= prox_inc;
            inst_valida <= 1'b1;
            estado      <= BUSCA;
          end
        end
        BUSCA: begin
          if (bus.desvio) begin
            if ({1'b0, bus.desvio_alvo} < LIMITE) begin
              pc_inst     <= prox;
              pc          <= prox_inc;
              inst_valida <= 1'b1;
            end else begin
              inst_valida <= 1'b0;
              fim         <= 1'b1;
              estado      <= FIM;
            end
          end else if (!bus.stall) begin
            if (pc < LIMITE) begin
              pc_inst <= prox;
              pc      <= prox_inc;
            end else begin
              inst_valida <= 1'b0;
              fim         <= 1'b1;
              estado      <= FIM;
            end
          end
        end
        default: begin
          // Terminal state (unused encodings fold into it); only reset leaves
          inst_valida <= 1'b0;
          fim         <= 1'b1;
          estado      <= FIM;
        end
      endcase
    end
  end

  contador_saturado #(
    .LARGURA (LARGURA)
  ) u_contador (
    .clock    (clock),
    .reset    (reset),
    .habilita (aceita),
    .valor    (contagem)
  );

  assign bus.endereco    = prox;
  assign bus.pc_inst     = pc_inst;
  assign bus.inst_valida = inst_valida;
  assign bus.fim         = fim;
  assign bus.contagem    = contagem;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench: busca_instrucao driving bancoInstrucoes through the reference program.
// Checks sampled 1 time unit after each rising edge.
// Covers sequential fetch, stall hold, branch redirect, end of program, out-of-range branch, reset.
module tb_busca_instrucao;

  logic       clock;
  logic       reset;
  logic [7:0] out;
  logic [7:0] rom [0:10];

  int checks;
  int errors;

  busca_instrucao_if #(.LARGURA(8)) bus ();

  busca_instrucao #(
    .LARGURA   (8),
    .END_RESET (0),
    .NUM_INSTR (11)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  bancoInstrucoes u_banco (
    .clock    (clock),
    .endereco (bus.endereco),
    .out      (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic passo();
    @(posedge clock);
    #1;
  endtask

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    assert (obs === esp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
    end
  endtask

  // Reset for two edges, then release; leaves the DUT in INICIO
  task automatic reinicia();
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.desvio = 1'b0;
    bus.desvio_alvo = 8'd0;
    passo();
    passo();
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rom[0]  = 8'b00010001; rom[1] = 8'b00100010; rom[2]  = 8'b01110010;
    rom[3]  = 8'b01000011; rom[4] = 8'b00101101; rom[5]  = 8'b01010100;
    rom[6]  = 8'b10000101; rom[7] = 8'b01100110; rom[8]  = 8'b10010111;
    rom[9]  = 8'b10101000; rom[10] = 8'b11110000;

    // Reset state
    reinicia();
    verifica("rst_pc_inst", bus.pc_inst, 0);
    verifica("rst_valida", bus.inst_valida, 0);
    verifica("rst_fim", bus.fim, 0);
    verifica("rst_contagem", bus.contagem, 0);
    verifica("rst_endereco", bus.endereco, 0);

    // 1. Sequential fetch from address 0
    passo();
    verifica("t1_valida", bus.inst_valida, 1);
    verifica("t1_pc_inst0", bus.pc_inst, 0);
    verifica("t1_out0", out, 8'b00010001);
    verifica("t1_endereco1", bus.endereco, 1);
    verifica("t1_contagem0", bus.contagem, 0);
    for (int i = 1; i <= 4; i++) begin
      passo();
      verifica("t1_pc_inst", bus.pc_inst, i);
      verifica("t1_out", out, rom[i]);
      verifica("t1_contagem", bus.contagem, i);
    end

    // 2. Stall three cycles at pc_inst=4
    bus.stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      passo();
      verifica("t2_pc_inst", bus.pc_inst, 4);
      verifica("t2_out", out, 8'b00101101);
      verifica("t2_endereco", bus.endereco, 4);
      verifica("t2_contagem", bus.contagem, 4);
      verifica("t2_valida", bus.inst_valida, 1);
    end
    bus.stall = 1'b0;
    passo();
    verifica("t2_resume_pc", bus.pc_inst, 5);
    verifica("t2_resume_out", out, rom[5]);
    verifica("t2_resume_cnt", bus.contagem, 5);
    passo();
    verifica("t2_pc6", bus.pc_inst, 6);

    // 3. Branch to 2 while pc_inst=6
    bus.desvio = 1'b1;
    bus.desvio_alvo = 8'd2;
    #1;
    verifica("t3_endereco", bus.endereco, 2);
    passo();
    bus.desvio = 1'b0;
    verifica("t3_pc_inst", bus.pc_inst, 2);
    verifica("t3_out", out, 8'b01110010);
    verifica("t3_valida", bus.inst_valida, 1);
    verifica("t3_contagem", bus.contagem, 7);
    passo();
    verifica("t3_pc_next", bus.pc_inst, 3);
    verifica("t3_out_next", out, rom[3]);
    verifica("t3_cnt_next", bus.contagem, 8);

    // 4. Free run from reset to end of program
    reinicia();
    passo();
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) passo();
      verifica("t4_pc_inst", bus.pc_inst, i);
      verifica("t4_out", out, rom[i]);
    end
    passo();
    verifica("t4_fim", bus.fim, 1);
    verifica("t4_valida", bus.inst_valida, 0);
    verifica("t4_endereco", bus.endereco, 10);
    verifica("t4_contagem", bus.contagem, 11);
    for (int k = 0; k < 20; k++) begin
      passo();
      verifica("t4_hold_fim", bus.fim, 1);
      verifica("t4_hold_valida", bus.inst_valida, 0);
      verifica("t4_hold_end", bus.endereco, 10);
      verifica("t4_hold_cnt", bus.contagem, 11);
    end

    // 5. Branch out of range while pc_inst=3
    reinicia();
    passo();
    for (int i = 1; i <= 3; i++) passo();
    verifica("t5_pc3", bus.pc_inst, 3);
    bus.desvio = 1'b1;
    bus.desvio_alvo = 8'd11;
    passo();
    bus.desvio = 1'b0;
    verifica("t5_fim", bus.fim, 1);
    verifica("t5_valida", bus.inst_valida, 0);
    verifica("t5_pc_hold", bus.pc_inst, 3);
    verifica("t5_endereco", bus.endereco, 3);
    verifica("t5_contagem", bus.contagem, 4);
    passo();
    verifica("t5_fim_hold", bus.fim, 1);
    verifica("t5_pc_hold2", bus.pc_inst, 3);

    // 6. Reset mid-run with stall and desvio high
    reinicia();
    passo();
    for (int i = 1; i <= 7; i++) passo();
    verifica("t6_pc7", bus.pc_inst, 7);
    bus.stall = 1'b1;
    bus.desvio = 1'b1;
    bus.desvio_alvo = 8'd5;
    reset = 1'b0;
    passo();
    verifica("t6_pc_inst", bus.pc_inst, 0);
    verifica("t6_valida", bus.inst_valida, 0);
    verifica("t6_fim", bus.fim, 0);
    verifica("t6_contagem", bus.contagem, 0);
    verifica("t6_endereco", bus.endereco, 0);
    reset = 1'b1;
    passo();
    bus.stall = 1'b0;
    bus.desvio = 1'b0;
    verifica("t6_restart_valida", bus.inst_valida, 1);
    verifica("t6_restart_pc", bus.pc_inst, 0);
    verifica("t6_restart_out", out, rom[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
